// File: rtl/arm_pkg.sv
// Shared definitions for the data-memory SRAM path: controller state encoding
// and the byte address at which the external SRAM is mapped.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/wait_counter.sv
// Phase timer for the SRAM controller: counts cycles spent in a phase and
// flags the terminal cycle. Clear has priority over enable.
module wait_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned TERM  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic term
);

    logic [WIDTH-1:0] count_q, count_d;

    // NOTE: combinational next-state gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term = (count_q == WIDTH'(TERM));

endmodule

// File: rtl/sram_controller.sv
// Sequences each 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM
// as two timed half-word accesses; ~ready is the pipeline freeze.
module sram_controller
    import arm_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int unsigned CW = $clog2(WAIT_CYCLES) + 1;

    sram_state_t        state_q, state_d;
    logic               is_write_q, is_write_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        read_data_q, read_data_d;
    logic               req;
    logic               phase_done;
    logic               in_phase;

    assign req      = rd_en | wr_en;
    assign in_phase = (state_q == LO) || (state_q == HI);

    wait_counter #(
        .WIDTH (CW),
        .TERM  (WAIT_CYCLES - 1)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_d != state_q),
        .enable (in_phase),
        .term   (phase_done)
    );

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    // Request is captured here; later input changes are ignored.
                    state_d    = LO;
                    is_write_d = wr_en;
                    word_d     = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);
                    wdata_d    = write_data;
                end
            end
            LO: begin
                if (phase_done) begin
                    state_d = HI;
                    if (!is_write_q) read_data_d[15:0] = sram_dq_in;
                end
            end
            HI: begin
                if (phase_done) begin
                    state_d = DONE;
                    if (!is_write_q) read_data_d[31:16] = sram_dq_in;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            is_write_q  <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // Pin outputs decode straight from state so reset releases the strobe at once.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        if (state_q == LO) begin
            sram_addr   = {word_q, 1'b0};
            sram_dq_out = is_write_q ? wdata_q[15:0] : 16'h0000;
            sram_dq_oe  = is_write_q;
            sram_we_n   = ~is_write_q;
        end else if (state_q == HI) begin
            sram_addr   = {word_q, 1'b1};
            sram_dq_out = is_write_q ? wdata_q[31:16] : 16'h0000;
            sram_dq_oe  = is_write_q;
            sram_we_n   = ~is_write_q;
        end
    end

    assign ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM plus a word-level
// reference memory, directed scenarios and randomized accesses.
module tb_sram_controller;
    import arm_pkg::*;

    localparam int W   = 3;
    localparam int AW  = 18;
    localparam int LAT = 2 * W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en, wr_en;
    logic [31:0]   address, write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_words [int unsigned];
    logic [31:0] ref_read;

    always #5 clk = ~clk;

    sram_controller #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (SRAM_BASE_ADDR),
        .SRAM_AW     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    // Behavioural asynchronous SRAM: write while we_n low, combinational read.
    logic [15:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
    assign sram_dq_in = sram_mem[sram_addr];

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - SRAM_BASE_ADDR;
        return (d / 4) % (1 << (AW - 1));
    endfunction

    // One complete access; optionally drops the request or moves the address mid-way.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int drop_cyc,
                          input int move_cyc, input logic [31:0] move_addr,
                          input string name);
        int unsigned  w;
        bit           is_wr;
        logic [AW-1:0] ea;
        logic [15:0]  ed;
        is_wr = wr;
        w     = word_of(addr);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = addr; write_data = data;
        for (int c = 0; c <= LAT; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == drop_cyc) begin rd_en = 1'b0; wr_en = 1'b0; end
                if (c == move_cyc) begin address = move_addr; write_data = ~data; end
            end
            @(negedge clk);
            checks++;
            if (ready !== (c == LAT)) begin
                errors++;
                $display("FAIL %s ready cycle %0d: got %b want %b", name, c, ready, (c == LAT));
            end
            if (c >= 1 && c <= 2 * W) begin
                ea = AW'(2 * w + ((c > W) ? 1 : 0));
                ed = (c > W) ? data[31:16] : data[15:0];
                checks++;
                if (sram_addr !== ea || sram_we_n !== !is_wr || sram_dq_oe !== is_wr ||
                    (is_wr && sram_dq_out !== ed)) begin
                    errors++;
                    $display("FAIL %s pins cycle %0d: got addr=%h we_n=%b oe=%b dq=%h want addr=%h we_n=%b oe=%b dq=%h",
                             name, c, sram_addr, sram_we_n, sram_dq_oe, sram_dq_out, ea, !is_wr, is_wr, ed);
                end
            end
        end
        if (is_wr) ref_words[w] = data;
        else       ref_read = ref_words.exists(w) ? ref_words[w] : 32'h0;
        checks++;
        if (read_data !== ref_read) begin
            errors++;
            $display("FAIL %s read_data: got %h want %h", name, read_data, ref_read);
        end
        if (is_wr) begin
            checks++;
            if ({sram_mem[2*w+1], sram_mem[2*w]} !== data) begin
                errors++;
                $display("FAIL %s sram word %0d: got %h want %h", name, w,
                         {sram_mem[2*w+1], sram_mem[2*w]}, data);
            end
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
            errors++;
            $display("FAIL %s idle after: got ready=%b we_n=%b want 1 1", name, ready, sram_we_n);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || read_data !== 32'h0 ||
                sram_dq_oe !== 1'b0 || sram_addr !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got ready=%b we_n=%b rd=%h oe=%b addr=%h want 1 1 0 0 0",
                         i, ready, sram_we_n, read_data, sram_dq_oe, sram_addr);
            end
        end
    endtask

    task automatic test_write_read();
        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, -1, -1, 32'h0, "write_1024");
        checks++;
        if (sram_mem[0] !== 16'hBEEF || sram_mem[1] !== 16'hDEAD) begin
            errors++;
            $display("FAIL write_halves: got %h %h want BEEF DEAD", sram_mem[0], sram_mem[1]);
        end
        access(1'b1, 1'b0, 32'd1024, 32'h0, -1, -1, 32'h0, "read_1024");
        access(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, -1, -1, 32'h0, "write_hold");
    endtask

    task automatic test_both_high();
        access(1'b1, 1'b1, 32'd1028, 32'h12345678, -1, -1, 32'h0, "both_high");
        checks++;
        if (sram_mem[2] !== 16'h5678 || sram_mem[3] !== 16'h1234) begin
            errors++;
            $display("FAIL both_high_halves: got %h %h want 5678 1234", sram_mem[2], sram_mem[3]);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1024 + 32'd400; write_data = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== '0 ||
            read_data !== 32'h0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_mid: got we_n=%b oe=%b addr=%h rd=%h state=%0d want 1 0 0 0 IDLE",
                     sram_we_n, sram_dq_oe, sram_addr, read_data, dut.state_q);
        end
        wr_en = 1'b0;
        ref_read = 32'h0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_release: got ready=%b we_n=%b want 1 1", ready, sram_we_n);
        end
    endtask

    task automatic test_mid_changes();
        access(1'b0, 1'b1, 32'd1032, 32'h0BAD_F00D, 1, -1, 32'h0, "drop_req");
        access(1'b0, 1'b1, 32'd1036, 32'h7654_3210, -1, 3, 32'd1040, "move_addr");
        access(1'b1, 1'b0, 32'd1036, 32'h0, -1, -1, 32'h0, "read_latched");
        access(1'b1, 1'b0, 32'd1040, 32'h0, -1, -1, 32'h0, "read_untouched");
    endtask

    task automatic test_random();
        int unsigned w, k, op, gap;
        logic [31:0] a, d;
        for (int n = 0; n < 24; n++) begin
            w  = $urandom_range(0, 63);
            k  = $urandom_range(0, 2);
            op = $urandom_range(0, 2);
            d  = $urandom;
            a  = SRAM_BASE_ADDR + 32'(4 * w) + 32'($urandom_range(0, 3));
            if (k == 1) a = a + 32'(1 << (AW + 1));
            if (k == 2) a = a - 32'(1 << (AW + 1));
            access(op != 0, op != 1, a, d, -1, -1, 32'h0, "random");
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL random_gap: got ready=%b want 1", ready);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        ref_read = 32'h0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_both_high();
        test_reset_mid();
        test_mid_changes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences the pipeline's data-memory accesses onto an external 16-bit asynchronous SRAM. It sits between the MEM stage and the SRAM pins. It turns each 32-bit load or store into two timed 16-bit half-word accesses. Its `ready` output, inverted, is the pipeline `freeze` that holds IF/ID/EXE/MEM while an access is in flight.

## Interface
Parameters:
- `WAIT_CYCLES`, 3: cycles each half-word access is held on the SRAM pins; legal range ≥1.
- `BASE_ADDR`, 1024: byte address mapped to SRAM half-word address 0.
- `SRAM_AW`, 18: SRAM half-word address width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous and active-high.
- `rd_en`  in  1  load request from MEM stage.
- `wr_en`  in  1  store request from MEM stage.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Val_Rm).
- `read_data`  out  32  registered load result.
- `ready`  out  1  high = no access pending or access completing this cycle; pipeline freeze = ~ready.
- `sram_addr`  out  SRAM_AW  SRAM half-word address.
- `sram_dq_out`  out  16  data driven to SRAM.
- `sram_dq_oe`  out  1  high = drive `sram_dq_out` onto the pad.
- `sram_dq_in`  in  16  data from SRAM.
- `sram_we_n`  out  1  SRAM write strobe, active-low.

## Operation
- Address map:
  - `word = (address - BASE_ADDR) >> 2`.
  - Low half uses `sram_addr = {word, 1'b0}`; high half uses `{word, 1'b1}`.
  - The address is truncated to SRAM_AW bits, so it wraps modulo the SRAM size and never errors.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE → LO when `rd_en | wr_en`.
  - LO → HI after WAIT_CYCLES cycles in LO.
  - HI → DONE after WAIT_CYCLES cycles in HI.
  - DONE → IDLE unconditionally.
- Wait counter: width `$clog2(WAIT_CYCLES)+1`. Cleared on every state entry. A phase ends when the counter reaches WAIT_CYCLES-1.
- Request latching:
  - Operation type, address and write_data are latched on the IDLE→LO transition.
  - Input changes mid-access are ignored.
  - Deasserting the request mid-access does not abort; the access completes.
- `rd_en` and `wr_en` both high: treated as a write.
- `ready` (combinational):
  - 1 in IDLE with no request.
  - 1 in DONE.
  - 0 otherwise, including IDLE with a request present.
- Writes:
  - During LO/HI, `sram_dq_oe`=1 and `sram_we_n`=0 for every cycle of the phase.
  - `sram_dq_out` carries `write_data[15:0]` in LO and `[31:16]` in HI.
- Reads:
  - `sram_we_n`=1 and `sram_dq_oe`=0.
  - `sram_dq_in` is captured into `read_data[15:0]` on the last LO cycle and into `[31:16]` on the last HI cycle.
  - `read_data` then holds until the next read completes; writes never alter it.
- Outside LO/HI: `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.

## Timing
- Reset values:
  - state IDLE, counter 0, `read_data` 0.
  - `sram_we_n` 1, `sram_dq_oe` 0, `sram_addr` 0, `sram_dq_out` 0.
  - `ready` 1 (no request present).
- Latency, counting the request cycle as cycle 0: `ready` rises in cycle 2·WAIT_CYCLES+1 (cycle 7 at default). The pipeline advances at the end of that cycle.
- Freeze duration: 2·WAIT_CYCLES+1 cycles per access. Non-memory instructions see 0 extra cycles.
- Back-to-back: a request present in the cycle after DONE starts a new access from IDLE. Minimum spacing between accesses is one IDLE cycle.
- Reset asserted mid-access:
  - All outputs take reset values immediately (asynchronously).
  - `sram_we_n` returns high within the same cycle.
  - A partial write may remain in the SRAM. This is accepted.
- The requester (MEM stage) holds request, address and data stable while `ready`=0. The controller does not depend on this, because it latches at IDLE→LO.

## Structure
- Shared package `arm_pkg`: the `sram_state_t` enum (IDLE, LO, HI, DONE) and the `SRAM_BASE_ADDR` constant, reused by the top level and the testbench SRAM model.
- One sub-module: `wait_counter` (clear, enable, terminal-count flag, parameterised width). Everything else stays in `sram_controller`.
- Testbench provides a behavioural 2^SRAM_AW × 16 SRAM model. The model samples on `sram_we_n` low and returns `sram_dq_in` combinationally.

## Test plan
- Reset, then idle with no requests → `ready`=1, `sram_we_n`=1, `read_data`=0 for 10 cycles.
- Write 0xDEADBEEF at 1024 → SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; `ready`=0 in cycles 0–6 and 1 in cycle 7.
- Read 1024 after that write → `read_data`=0xDEADBEEF when `ready` rises; value holds through a following write to 1028.
- Write 0x12345678 at 1028 with `rd_en` also high → treated as write; SRAM[2]=0x5678, SRAM[3]=0x1234.
- Assert `rst` in cycle 2 of a write → `sram_we_n`=1 and state IDLE immediately; after reset release, `ready`=1.
- Drop `wr_en` in cycle 1 of a write, and separately change `address` mid-access → access completes to the latched address; `ready` still rises in cycle 7.
